galapagos_packetizer: RTL and testbench
=======================================

Name: galapagos_packetizer

Overview:
- Stage directly downstream of data_width_converter in the FINN-to-Galapagos bridge.
- Consumes the converter's output stream (data, keep, last) and cuts it into Galapagos packets of at most MAX_BEATS beats.
- Attaches per-packet dest/id sidebands and drives a registered AXI-Stream master toward the Galapagos router.
- Provides full-throughput buffering through a 2-entry skid buffer so that o_input_ready is a registered signal.

Parameters:
- DATA_WIDTH, 64, stream width in bits; must be a multiple of 8 and match the converter's OUTPUT_WIDTH.
- MAX_BEATS, 4, maximum beats per packet; allowed range is 1 to 65535.
- DEST_WIDTH, 8, width of the Galapagos destination field.
- ID_WIDTH, 8, width of the Galapagos source-id field.

Ports:
- i_clk  in  1  single clock.
- i_aresetn  in  1  reset, asynchronous, active-low.
- i_input_valid  in  1  upstream beat valid.
- o_input_ready  out  1  upstream ready; registered.
- i_input_data  in  DATA_WIDTH  upstream payload.
- i_input_keep  in  DATA_WIDTH/8  upstream byte enables, contiguous from the LSB.
- i_input_last  in  1  end of stream from the converter.
- i_dest  in  DEST_WIDTH  destination for the next packet; quasi-static.
- i_id  in  ID_WIDTH  source id for the next packet; quasi-static.
- o_output_valid  out  1  downstream beat valid.
- i_output_ready  in  1  downstream ready.
- o_output_data  out  DATA_WIDTH  payload.
- o_output_keep  out  DATA_WIDTH/8  byte enables.
- o_output_last  out  1  last beat of the packet.
- o_output_dest  out  DEST_WIDTH  packet destination, constant for the whole packet.
- o_output_id  out  ID_WIDTH  packet source id, constant for the whole packet.
- o_packet_count  out  32  number of packets fully sent downstream; wraps at 2^32.

Behaviour:
- **Reset values:** while i_aresetn=0, every output is 0, including o_input_ready. The beat counter and skid buffer are emptied.
- **Leaving reset:** o_input_ready rises on the first i_clk edge after i_aresetn deasserts.
- **Handshakes:**
  - An input beat is accepted when i_input_valid and o_input_ready are both 1.
  - An output beat is transferred when o_output_valid and i_output_ready are both 1.
  - Once asserted, o_output_valid and all output fields hold stable until the beat is transferred.
- **Beat counter** (range 0 to MAX_BEATS-1), advanced on every accepted input beat:
  - last_cut = (counter == MAX_BEATS-1) OR i_input_last OR (i_input_keep != all ones).
  - If last_cut, the counter returns to 0; otherwise it increments.
  - A partial keep is treated as the end of the stream.
- **Dest/id capture:**
  - i_dest and i_id are sampled on the accepted beat where counter == 0.
  - The sampled values are applied to every beat of that packet.
  - Changing i_dest or i_id mid-packet has no effect until the next packet.
- **Packet states:** IDLE (counter == 0) and IN_PKT. IDLE goes to IN_PKT on an accepted beat without last_cut. IN_PKT returns to IDLE on an accepted beat with last_cut.
- **Skid buffer:**
  - 2 entries, each holding data, keep, last_cut, dest and id.
  - Latency is 1 cycle: a beat accepted at edge N is presented at o_output_* after edge N.
  - o_input_ready = (entry count < 2) registered, with lookahead, so that with ready held high the throughput is 1 beat per cycle.
  - Simultaneous push and pop with the buffer full is not allowed, because ready is already 0.
  - Simultaneous push and pop with 1 entry keeps the occupancy at 1.
- **Data path:** data and keep pass through unmodified. Beats with keep=0 are forwarded as-is and still count as beats.
- **o_packet_count:** increments by 1 on each transferred output beat with o_output_last=1.
- **Reset mid-packet:** the partial packet is discarded with no last emitted. o_packet_count returns to 0.
- **MAX_BEATS=1:** every beat carries last.

Decomposition:
- Package galapagos_pkg holds:
  - the default widths (GP_DATA_WIDTH=64, GP_DEST_WIDTH=8, GP_ID_WIDTH=8);
  - a packed struct gp_beat_t with fields data, keep, last, dest, id.
- Sub-module axis_skid_buffer: a generic 2-entry register slice parameterised by payload width and carrying a gp_beat_t. It is reusable by other bridge stages.
- The packetizer top contains the counter, the last_cut logic, the dest/id capture register and o_packet_count.

Test Plan:
1. **Reset hold:** i_aresetn=0 for 10 cycles with i_input_valid=1 -> o_input_ready=0, o_output_valid=0, o_packet_count=0. Then release -> o_input_ready=1 one edge later.
2. **Packet cut at MAX_BEATS:** MAX_BEATS=4; stream 10 full-keep beats, data 0x1..0xA, i_input_last on beat 10, downstream always ready -> last on beats 4, 8 and 10; o_packet_count=3; one output beat per cycle after 1-cycle latency.
3. **Partial keep:** beat 2 of a packet with keep=8'b00000111 and i_input_last=0 -> that beat is output with last=1 and keep 0x07; the next beat starts a new packet with counter 0.
4. **Backpressure:** i_output_ready toggles 1,0,0,1 while 8 beats stream in -> o_input_ready drops after 2 buffered beats; no beat is lost or duplicated; output order and data are 0x1..0x8.
5. **Dest/id capture:** i_dest=0x05 for beat 1, changed to 0x09 on beat 2, MAX_BEATS=4 -> beats 1-4 carry dest 0x05; beat 5 carries 0x09.
6. **Mid-packet reset:** reset asserted after 2 of 4 beats -> outputs are 0 immediately (asynchronously). After release, a fresh 4-beat packet carries last only on its 4th beat, and o_packet_count=1.

Source files
------------

// File: rtl/galapagos_pkg.sv
// Shared types and default widths for the FINN-to-Galapagos bridge stages.
package galapagos_pkg;

  localparam int GP_DATA_WIDTH = 64;
  localparam int GP_KEEP_WIDTH = GP_DATA_WIDTH / 8;
  localparam int GP_DEST_WIDTH = 8;
  localparam int GP_ID_WIDTH   = 8;

  typedef struct packed {
    logic [GP_DATA_WIDTH-1:0] data;
    logic [GP_KEEP_WIDTH-1:0] keep;
    logic                     last;
    logic [GP_DEST_WIDTH-1:0] dest;
    logic [GP_ID_WIDTH-1:0]   id;
  } gp_beat_t;

  typedef enum logic {
    IDLE,
    IN_PKT
  } pkt_state_t;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream register slice with a registered upstream ready.
// The payload is opaque; by default it is sized for one gp_beat_t.
module axis_skid_buffer
  import galapagos_pkg::*;
#(
  parameter int WIDTH = $bits(gp_beat_t)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_payload,
  output logic             dn_valid,
  input  logic             dn_ready,
  output logic [WIDTH-1:0] dn_payload
);

  logic [1:0]       count;
  logic [1:0]       count_next;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;
  logic             push;
  logic             pop;

  assign push       = up_valid & up_ready;
  assign pop        = dn_valid & dn_ready;
  assign dn_valid   = (count != 2'd0);
  assign dn_payload = head;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: count_next = count;
    endcase
  end

  // Ready is computed from the next occupancy so a steady 1-in/1-out flow never stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= 2'd0;
      up_ready <= 1'b0;
      head     <= '0;
      tail     <= '0;
    end else begin
      count    <= count_next;
      up_ready <= (count_next != 2'd2);
      if (push && ((count == 2'd0) || ((count == 2'd1) && pop))) begin
        head <= up_payload;
      end else if (pop && (count == 2'd2)) begin
        head <= tail;
      end
      if (push && (count == 2'd1) && !pop) begin
        tail <= up_payload;
      end
    end
  end

endmodule

// File: rtl/galapagos_packetizer.sv
// Cuts the converter stream into Galapagos packets of at most MAX_BEATS beats
// and tags each packet with the dest/id sampled on its first beat.
module galapagos_packetizer
  import galapagos_pkg::*;
#(
  parameter int DATA_WIDTH = GP_DATA_WIDTH,
  parameter int MAX_BEATS  = 4,
  parameter int DEST_WIDTH = GP_DEST_WIDTH,
  parameter int ID_WIDTH   = GP_ID_WIDTH
) (
  input  logic                    i_clk,
  input  logic                    i_aresetn,
  input  logic                    i_input_valid,
  output logic                    o_input_ready,
  input  logic [DATA_WIDTH-1:0]   i_input_data,
  input  logic [DATA_WIDTH/8-1:0] i_input_keep,
  input  logic                    i_input_last,
  input  logic [DEST_WIDTH-1:0]   i_dest,
  input  logic [ID_WIDTH-1:0]     i_id,
  output logic                    o_output_valid,
  input  logic                    i_output_ready,
  output logic [DATA_WIDTH-1:0]   o_output_data,
  output logic [DATA_WIDTH/8-1:0] o_output_keep,
  output logic                    o_output_last,
  output logic [DEST_WIDTH-1:0]   o_output_dest,
  output logic [ID_WIDTH-1:0]     o_output_id,
  output logic [31:0]             o_packet_count
);

  localparam int KEEP_WIDTH = DATA_WIDTH / 8;
  localparam int BEAT_WIDTH = DATA_WIDTH + KEEP_WIDTH + 1 + DEST_WIDTH + ID_WIDTH;

  pkt_state_t            state;
  pkt_state_t            state_next;
  logic [15:0]           beat_count;
  logic [DEST_WIDTH-1:0] dest_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic                  accept;
  logic                  last_cut;
  logic [DEST_WIDTH-1:0] beat_dest;
  logic [ID_WIDTH-1:0]   beat_id;
  logic [BEAT_WIDTH-1:0] up_payload;
  logic [BEAT_WIDTH-1:0] dn_payload;

  assign accept   = i_input_valid & o_input_ready;
  assign last_cut = (beat_count == 16'(MAX_BEATS - 1)) | i_input_last |
                    (i_input_keep != {KEEP_WIDTH{1'b1}});

  // The first beat of a packet uses the live dest/id; later beats reuse the captured copy.
  assign beat_dest = (state == IDLE) ? i_dest : dest_q;
  assign beat_id   = (state == IDLE) ? i_id   : id_q;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && !last_cut) state_next = IN_PKT;
      IN_PKT:  if (accept && last_cut)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      state      <= IDLE;
      beat_count <= 16'd0;
      dest_q     <= '0;
      id_q       <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        beat_count <= last_cut ? 16'd0 : beat_count + 16'd1;
        if (state == IDLE) begin
          dest_q <= i_dest;
          id_q   <= i_id;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      o_packet_count <= 32'd0;
    end else if (o_output_valid && i_output_ready && o_output_last) begin
      o_packet_count <= o_packet_count + 32'd1;
    end
  end

  assign up_payload = {i_input_data, i_input_keep, last_cut, beat_dest, beat_id};

  axis_skid_buffer #(
    .WIDTH(BEAT_WIDTH)
  ) u_skid (
    .clk       (i_clk),
    .rst_n     (i_aresetn),
    .up_valid  (i_input_valid),
    .up_ready  (o_input_ready),
    .up_payload(up_payload),
    .dn_valid  (o_output_valid),
    .dn_ready  (i_output_ready),
    .dn_payload(dn_payload)
  );

  assign {o_output_data, o_output_keep, o_output_last, o_output_dest, o_output_id} = dn_payload;

endmodule

// File: tb/tb_galapagos_packetizer.sv
// Self-checking bench for galapagos_packetizer: directed plan steps followed by a
// randomized stream, all compared against a packet-rule reference model.
module tb_galapagos_packetizer;

  localparam int MB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic [7:0]  in_keep = '0;
  logic        in_last = 1'b0;
  logic [7:0]  dest = '0;
  logic [7:0]  id = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic [7:0]  out_keep;
  logic        out_last;
  logic [7:0]  out_dest;
  logic [7:0]  out_id;
  logic [31:0] pkt_count;

  galapagos_packetizer #(
    .DATA_WIDTH(64),
    .MAX_BEATS (MB),
    .DEST_WIDTH(8),
    .ID_WIDTH  (8)
  ) dut (
    .i_clk         (clk),
    .i_aresetn     (rst_n),
    .i_input_valid (in_valid),
    .o_input_ready (in_ready),
    .i_input_data  (in_data),
    .i_input_keep  (in_keep),
    .i_input_last  (in_last),
    .i_dest        (dest),
    .i_id          (id),
    .o_output_valid(out_valid),
    .i_output_ready(out_ready),
    .o_output_data (out_data),
    .o_output_keep (out_keep),
    .o_output_last (out_last),
    .o_output_dest (out_dest),
    .o_output_id   (out_id),
    .o_packet_count(pkt_count)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle++;

  // Downstream ready source: 0 = constant, 1 = 1,0,0,1 pattern, 2 = random.
  int   rdy_mode = 0;
  logic rdy_const = 1'b1;
  always begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      1:       out_ready = ((cycle % 4) == 0) || ((cycle % 4) == 3);
      2:       out_ready = ($urandom % 4) != 0;
      default: out_ready = rdy_const;
    endcase
  end

  // Beats are stored as {data, keep, last, dest, id} plus the cycle they were seen.
  typedef struct {
    logic [88:0] b;
    int          stamp;
  } rec_t;

  rec_t        in_q[$];
  rec_t        out_q[$];
  int          hold_viol = 0;
  int          stall_seen = 0;
  logic        hold_p = 1'b0;
  logic [88:0] hold_v = '0;

  // Observer: records accepted/transferred beats and watches output stability under stall.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_p = 1'b0;
    end else begin
      if (hold_p && ({out_valid, out_data, out_keep, out_last, out_dest, out_id} !== {1'b1, hold_v}))
        hold_viol++;
      if (in_valid && in_ready)
        in_q.push_back('{b: {in_data, in_keep, in_last, dest, id}, stamp: cycle});
      if (in_valid && !in_ready)
        stall_seen++;
      if (out_valid && out_ready)
        out_q.push_back('{b: {out_data, out_keep, out_last, out_dest, out_id}, stamp: cycle});
      hold_p = out_valid && !out_ready;
      hold_v = {out_data, out_keep, out_last, out_dest, out_id};
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idleCycles(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [63:0] d, input logic [7:0] k, input logic l,
                               input logic [7:0] ds, input logic [7:0] i, input int gap);
    logic r;
    bit   done;
    if (gap > 0) idleCycles(gap);
    in_valid = 1'b1;
    in_data  = d;
    in_keep  = k;
    in_last  = l;
    dest     = ds;
    id       = i;
    done     = 1'b0;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      #1;
      if (r) done = 1'b1;
    end
    if (!done) checkOutput("accept_timeout", 128'(0), 128'(1));
  endtask

  task automatic waitOutputs(input int target);
    for (int t = 0; t < 400 && out_q.size() < target; t++) @(posedge clk);
    #1;
  endtask

  // Reference model: a packet closes after MB beats, on last, or on any partial keep;
  // dest/id of a packet are those present on its first beat.
  task automatic modelCheck(input string tag, input int in_lo, input int out_lo, output int lasts);
    int          pos;
    logic [7:0]  pd;
    logic [7:0]  pi;
    logic        cut;
    logic [88:0] b;
    logic [88:0] expv;
    pos   = 0;
    pd    = '0;
    pi    = '0;
    lasts = 0;
    checkOutput({tag, "_beats"}, 128'(out_q.size() - out_lo), 128'(in_q.size() - in_lo));
    for (int k = in_lo; k < in_q.size(); k++) begin
      b = in_q[k].b;
      if (pos == 0) begin
        pd = b[15:8];
        pi = b[7:0];
      end
      pos++;
      cut = (pos == MB) || b[16] || (b[24:17] != 8'hFF);
      if (cut) begin
        pos = 0;
        lasts++;
      end
      expv = {b[88:17], cut, pd, pi};
      if (out_lo + (k - in_lo) < out_q.size())
        checkOutput(tag, 128'(out_q[out_lo + (k - in_lo)].b), 128'(expv));
    end
  endtask

  initial begin
    int ib;
    int ob;
    int lasts;
    int exp_pkts;
    int stall0;
    int n_rand;
    logic [7:0] k;

    // 1. Reset hold with valid asserted.
    in_valid = 1'b1;
    in_keep  = 8'hFF;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 128'(in_ready), 128'(0));
    checkOutput("rst_out_valid", 128'(out_valid), 128'(0));
    checkOutput("rst_pkt_count", 128'(pkt_count), 128'(0));
    checkOutput("rst_out_fields", 128'({out_data, out_keep, out_last, out_dest, out_id}), 128'(0));
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rel_ready_before_edge", 128'(in_ready), 128'(0));
    @(posedge clk);
    #1;
    checkOutput("rel_ready_after_edge", 128'(in_ready), 128'(1));

    // 2. Ten full beats, last on beat 10, downstream always ready.
    exp_pkts = 0;
    rdy_mode = 0;
    rdy_const = 1'b1;
    ib = in_q.size();
    ob = out_q.size();
    for (int n = 1; n <= 10; n++)
      applyStimulus(64'(n), 8'hFF, (n == 10), 8'h01, 8'h02, 0);
    idleCycles(1);
    waitOutputs(ob + 10);
    modelCheck("t2", ib, ob, lasts);
    exp_pkts += lasts;
    checkOutput("t2_lasts", 128'(lasts), 128'(3));
    checkOutput("t2_last_beat4", 128'(out_q[ob + 3].b[16]), 128'(1));
    checkOutput("t2_latency", 128'(out_q[ob].stamp - in_q[ib].stamp), 128'(1));
    checkOutput("t2_span", 128'(out_q[ob + 9].stamp - out_q[ob].stamp), 128'(9));
    checkOutput("t2_pkt_count", 128'(pkt_count), 128'(3));

    // 3. Partial keep on beat 2 closes the packet; beat 3 starts a new one.
    ib = in_q.size();
    ob = out_q.size();
    applyStimulus(64'hA1, 8'hFF, 1'b0, 8'h22, 8'h01, 0);
    applyStimulus(64'hA2, 8'h07, 1'b0, 8'h22, 8'h01, 0);
    applyStimulus(64'hA3, 8'hFF, 1'b0, 8'h33, 8'h01, 0);
    applyStimulus(64'hA4, 8'hFF, 1'b1, 8'h44, 8'h01, 0);
    idleCycles(1);
    waitOutputs(ob + 4);
    modelCheck("t3", ib, ob, lasts);
    exp_pkts += lasts;
    checkOutput("t3_partial_keep_last", 128'({out_q[ob + 1].b[24:16]}), 128'({8'h07, 1'b1}));
    checkOutput("t3_new_pkt_dest", 128'(out_q[ob + 2].b[15:8]), 128'(8'h33));

    // 4. Backpressure with ready pattern 1,0,0,1.
    ib = in_q.size();
    ob = out_q.size();
    stall0 = stall_seen;
    rdy_mode = 1;
    for (int n = 1; n <= 8; n++)
      applyStimulus(64'(n), 8'hFF, 1'b0, 8'h07, 8'h08, 0);
    idleCycles(1);
    waitOutputs(ob + 8);
    rdy_mode = 0;
    modelCheck("t4", ib, ob, lasts);
    exp_pkts += lasts;
    checkOutput("t4_ready_dropped", 128'(stall_seen > stall0), 128'(1));
    checkOutput("t4_last_data", 128'(out_q[ob + 7].b[88:25]), 128'(64'h8));

    // 5. Dest/id changed after the first beat apply only from the next packet.
    ib = in_q.size();
    ob = out_q.size();
    applyStimulus(64'hD1, 8'hFF, 1'b0, 8'h05, 8'h11, 0);
    for (int n = 2; n <= 5; n++)
      applyStimulus(64'(n + 'hD0), 8'hFF, 1'b0, 8'h09, 8'h22, 0);
    idleCycles(1);
    waitOutputs(ob + 5);
    modelCheck("t5", ib, ob, lasts);
    exp_pkts += lasts;
    checkOutput("t5_beat4_dest_id", 128'(out_q[ob + 3].b[15:0]), 128'(16'h0511));
    checkOutput("t5_beat5_dest_id", 128'(out_q[ob + 4].b[15:0]), 128'(16'h0922));
    checkOutput("t5_pkt_count", 128'(pkt_count), 128'(exp_pkts));

    // 6. Reset asserted mid-packet while beats sit in the buffer.
    rdy_const = 1'b0;
    idleCycles(2);
    applyStimulus(64'hE1, 8'hFF, 1'b0, 8'h01, 8'h01, 0);
    applyStimulus(64'hE2, 8'hFF, 1'b0, 8'h01, 8'h01, 0);
    idleCycles(1);
    checkOutput("t6_buffered_before_rst", 128'(out_valid), 128'(1));
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_async_out_valid", 128'(out_valid), 128'(0));
    checkOutput("t6_async_in_ready", 128'(in_ready), 128'(0));
    checkOutput("t6_async_pkt_count", 128'(pkt_count), 128'(0));
    rdy_const = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_pkts = 0;
    ib = in_q.size();
    ob = out_q.size();
    for (int n = 1; n <= 4; n++)
      applyStimulus(64'(n + 'hF0), 8'hFF, 1'b0, 8'h0C, 8'h0D, 0);
    idleCycles(1);
    waitOutputs(ob + 4);
    modelCheck("t6", ib, ob, lasts);
    exp_pkts += lasts;
    checkOutput("t6_last_pattern",
                128'({out_q[ob].b[16], out_q[ob + 1].b[16], out_q[ob + 2].b[16], out_q[ob + 3].b[16]}),
                128'(4'b0001));
    checkOutput("t6_pkt_count", 128'(pkt_count), 128'(1));

    // 7. Randomized stream with random gaps, keeps, lasts, dest/id and ready.
    ib = in_q.size();
    ob = out_q.size();
    rdy_mode = 2;
    n_rand = 150;
    for (int n = 0; n < n_rand; n++) begin
      k = (($urandom % 6) == 0) ? 8'(8'hFF >> $urandom_range(1, 8)) : 8'hFF;
      applyStimulus({$urandom, $urandom}, k, (($urandom % 10) == 0),
                    8'($urandom), 8'($urandom), (($urandom % 3) == 0) ? 1 : 0);
    end
    idleCycles(1);
    rdy_mode = 0;
    rdy_const = 1'b1;
    waitOutputs(ob + n_rand);
    modelCheck("t7", ib, ob, lasts);
    exp_pkts += lasts;
    idleCycles(2);
    checkOutput("t7_pkt_count", 128'(pkt_count), 128'(exp_pkts));
    checkOutput("t7_out_idle", 128'(out_valid), 128'(0));
    checkOutput("hold_stable", 128'(hold_viol), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
